// File: rtl/sample_voice_mixer.sv
// sample_voice_mixer: polyphonic sample playback with time-multiplexed ROM fetch and saturating stereo mix.
module sample_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_LEN = 4096,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VOICES-1:0]   trigger,
  input  logic [NUM_VOICES-1:0]   loop_en,
  input  logic                    stop,
  input  logic                    audio_out_allowed,
  output logic                    write_audio_out,
  output logic [DATA_W-1:0]       left_out,
  output logic [DATA_W-1:0]       right_out,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [2*DATA_W-1:0]     rom_q,
  output logic [NUM_VOICES-1:0]   active,
  output logic                    busy
);
  localparam int PW = $clog2(SAMPLE_LEN);
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int AW = DATA_W + $clog2(NUM_VOICES);
  localparam int KN = NUM_VOICES + ROM_LAT;
  localparam int KW = $clog2(KN + 1);
  localparam logic signed [AW-1:0] MX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MN = ~MX;

  if (longint'(NUM_VOICES) * longint'(SAMPLE_LEN) > (longint'(1) << ADDR_W)) begin : g_chk
    $error("sample_voice_mixer: NUM_VOICES*SAMPLE_LEN exceeds ROM address space");
  end

  typedef enum logic [2:0] {IDLE, WAIT_ALLOWED, FETCH, OUTPUT, GAP} state_t;
  state_t state, state_n;

  logic [KW-1:0]          k;
  logic [PW-1:0]          pos [NUM_VOICES];
  logic [NUM_VOICES-1:0]  pend;
  logic signed [AW-1:0]   acc_l, acc_r, acc_l_n, acc_r_n;
  logic [VW-1:0]          vi, vj;
  logic                   take, apply, last;

  function automatic logic [DATA_W-1:0] sat(input logic signed [AW-1:0] a);
    return a > MX ? MX[DATA_W-1:0] : a < MN ? MN[DATA_W-1:0] : a[DATA_W-1:0];
  endfunction

  always_comb begin
    vi = VW'(k);
    vj = VW'(k - KW'(ROM_LAT));
    last = k == KW'(KN - 1);
    apply = state == WAIT_ALLOWED && audio_out_allowed;
    // data for voice k-ROM_LAT arrives now; silent voices contribute nothing
    take = state == FETCH && k >= KW'(ROM_LAT) && active[vj];
    acc_l_n = acc_l + (take ? AW'($signed(rom_q[2*DATA_W-1:DATA_W])) : '0);
    acc_r_n = acc_r + (take ? AW'($signed(rom_q[DATA_W-1:0])) : '0);
    rom_addr = (state == FETCH && k < KW'(NUM_VOICES)) ? ADDR_W'({vi, pos[vi]}) : '0;
    write_audio_out = state == OUTPUT && !stop;
    busy = state != IDLE;
    state_n = state;
    if (stop) state_n = IDLE;
    else
      case (state)
        IDLE:         state_n = (|pend || |trigger) ? WAIT_ALLOWED : IDLE;
        WAIT_ALLOWED: state_n = audio_out_allowed ? FETCH : WAIT_ALLOWED;
        FETCH:        state_n = last ? OUTPUT : FETCH;
        OUTPUT:       state_n = GAP;
        GAP:          state_n = (|active || |pend || |trigger) ? WAIT_ALLOWED : IDLE;
        default:      state_n = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k <= '0;
      acc_l <= '0;
      acc_r <= '0;
      left_out <= '0;
      right_out <= '0;
      active <= '0;
      pend <= '0;
      for (int v = 0; v < NUM_VOICES; v++) pos[v] <= '0;
    end else begin
      state <= state_n;
      k <= state == FETCH ? k + 1'b1 : '0;
      acc_l <= state == FETCH ? acc_l_n : '0;
      acc_r <= state == FETCH ? acc_r_n : '0;
      if (state_n == IDLE) begin
        left_out <= '0;
        right_out <= '0;
      end else if (state == FETCH && last) begin
        left_out <= sat(acc_l_n);
        right_out <= sat(acc_r_n);
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (stop) begin
          active[v] <= 1'b0;
          pend[v] <= 1'b0;
        end else if (apply) begin
          if (pend[v] || trigger[v]) begin
            pos[v] <= '0;
            active[v] <= 1'b1;
          end
          pend[v] <= 1'b0;
        end else begin
          pend[v] <= pend[v] | trigger[v];
          if (state == OUTPUT && active[v]) begin
            if (pos[v] != PW'(SAMPLE_LEN - 1)) pos[v] <= pos[v] + 1'b1;
            else if (loop_en[v]) pos[v] <= '0;
            else active[v] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sample_voice_mixer.sv
// tb_sample_voice_mixer: directed checks of playback, mixing, saturation, backpressure and abort.
module tb_sample_voice_mixer;
  localparam int NV = 4, SL = 8, AW = 16, DW = 16, RL = 2;

  logic            clk = 0, rst = 0;
  logic [NV-1:0]   trigger = '0, loop_en = '0;
  logic            stop = 0, audio_out_allowed = 1;
  logic            write_audio_out, busy;
  logic [DW-1:0]   left_out, right_out;
  logic [AW-1:0]   rom_addr;
  logic [2*DW-1:0] rom_q;
  logic [NV-1:0]   active;

  logic [2*DW-1:0] rom [NV*SL];
  logic [2*DW-1:0] d1, d2;
  int checks = 0, errors = 0;

  logic [15:0] sat_l [2][4] = '{'{16'h7000, 16'h7000, 16'h7000, 16'h7000}, '{16'h1000, 16'h1000, 16'h1000, 16'h1000}};
  logic [15:0] sat_r [2][4] = '{'{16'h9000, 16'h9000, 16'h9000, 16'h9000}, '{16'h7000, 16'h9000, 16'h0000, 16'h0000}};
  logic [15:0] exp_l [2] = '{16'h7fff, 16'h4000};
  logic [15:0] exp_r [2] = '{16'h8000, 16'h0000};

  sample_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_LEN(SL), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(RL)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .loop_en(loop_en), .stop(stop),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_out(left_out), .right_out(right_out), .rom_addr(rom_addr), .rom_q(rom_q),
    .active(active), .busy(busy)
  );

  always #5 clk = ~clk;

  // two-stage registered ROM
  always @(posedge clk) begin
    d1 <= rom[rom_addr[4:0]];
    d2 <= d1;
  end
  assign rom_q = d2;

  task automatic clear_rom;
    for (int i = 0; i < NV*SL; i++) rom[i] = '0;
  endtask

  task automatic pulse(input logic [NV-1:0] t);
    trigger = t;
    @(negedge clk);
    trigger = '0;
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (write_audio_out) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_stop;
    stop = 1;
    @(negedge clk);
    stop = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (write_audio_out !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", write_audio_out); end
    checks++; if ({left_out, right_out} !== 32'h0) begin errors++; $display("FAIL rst_out got %h exp 0", {left_out, right_out}); end
    checks++; if (rom_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", rom_addr); end
    checks++; if ({active, busy} !== 5'b0) begin errors++; $display("FAIL rst_active_busy got %b exp 0", {active, busy}); end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_single_voice;
    int n;
    clear_rom();
    for (int p = 0; p < SL; p++) rom[SL+p] = {16'(p*256), 16'(-(p*256))};
    pulse(4'b0010);
    wait_strobe(20, n);
    checks++; if (n + 1 !== 8) begin errors++; $display("FAIL sv_latency got %0d exp 8", n + 1); end
    for (int p = 0; p < SL; p++) begin
      if (p > 0) begin
        wait_strobe(20, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL sv_period p=%0d got %0d exp 9", p, n); end
      end
      checks++; if (left_out !== 16'(p*256) || right_out !== 16'(-(p*256)))
        begin errors++; $display("FAIL sv_data p=%0d got %h/%h exp %h/%h", p, left_out, right_out, 16'(p*256), 16'(-(p*256))); end
      checks++; if (active[1] !== 1'b1) begin errors++; $display("FAIL sv_active p=%0d got %b exp 1", p, active[1]); end
    end
    @(negedge clk);
    checks++; if (active[1] !== 1'b0) begin errors++; $display("FAIL sv_end_active got %b exp 0", active[1]); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sv_idle busy got %b exp 0", busy); end
    wait_strobe(30, n);
    checks++; if (n !== -1) begin errors++; $display("FAIL sv_no_extra got strobe at %0d exp none", n); end
  endtask

  task automatic test_saturation;
    int n;
    for (int c = 0; c < 2; c++) begin
      clear_rom();
      for (int v = 0; v < NV; v++) rom[v*SL] = {sat_l[c][v], sat_r[c][v]};
      pulse(4'hf);
      wait_strobe(20, n);
      checks++; if (left_out !== exp_l[c]) begin errors++; $display("FAIL sat_left c=%0d got %h exp %h", c, left_out, exp_l[c]); end
      checks++; if (right_out !== exp_r[c]) begin errors++; $display("FAIL sat_right c=%0d got %h exp %h", c, right_out, exp_r[c]); end
      do_stop();
    end
  endtask

  task automatic test_retrigger_loop;
    int n;
    clear_rom();
    for (int p = 0; p < SL; p++) rom[p] = {16'(256*(p+1)), 16'(p)};
    pulse(4'b0001);
    for (int i = 0; i < 6; i++) wait_strobe(20, n);
    checks++; if (left_out !== 16'h0600) begin errors++; $display("FAIL rt_pos5 got %h exp 0600", left_out); end
    pulse(4'b0001);
    wait_strobe(20, n);
    checks++; if ({left_out, right_out} !== 32'h0100_0000) begin errors++; $display("FAIL rt_restart got %h exp 01000000", {left_out, right_out}); end
    loop_en = 4'b0001;
    for (int i = 0; i < 7; i++) wait_strobe(20, n);
    checks++; if ({left_out, right_out} !== 32'h0800_0007) begin errors++; $display("FAIL lp_pos7 got %h exp 08000007", {left_out, right_out}); end
    wait_strobe(20, n);
    checks++; if (n !== 9 || left_out !== 16'h0100) begin errors++; $display("FAIL lp_wrap got n=%0d %h exp n=9 0100", n, left_out); end
    checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL lp_active got %b exp 1", active[0]); end
    loop_en = '0;
    do_stop();
  endtask

  task automatic test_backpressure;
    int n, bad;
    pulse(4'b0001);
    wait_strobe(20, n);
    checks++; if (left_out !== 16'h0100) begin errors++; $display("FAIL bp_first got %h exp 0100", left_out); end
    audio_out_allowed = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (write_audio_out !== 1'b0 || rom_addr !== 16'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL bp_active got %b exp 1", active[0]); end
    audio_out_allowed = 1;
    wait_strobe(20, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL bp_resume_lat got %0d exp 7", n); end
    checks++; if (left_out !== 16'h0200) begin errors++; $display("FAIL bp_resume_pos got %h exp 0200", left_out); end
    do_stop();
  endtask

  task automatic test_abort;
    int n;
    pulse(4'b0001);
    wait_strobe(20, n);
    repeat (3) @(negedge clk);
    checks++; if (rom_addr !== 16'd1) begin errors++; $display("FAIL ab_fetch_addr got %h exp 0001", rom_addr); end
    repeat (2) @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    checks++; if ({busy, active, write_audio_out} !== 6'b0) begin errors++; $display("FAIL ab_state got %b exp 0", {busy, active, write_audio_out}); end
    checks++; if ({left_out, right_out} !== 32'h0) begin errors++; $display("FAIL ab_out got %h exp 0", {left_out, right_out}); end
    wait_strobe(30, n);
    checks++; if (n !== -1) begin errors++; $display("FAIL ab_no_strobe got %0d exp none", n); end
  endtask

  task automatic test_reset_mid_output;
    int n;
    pulse(4'b0001);
    wait_strobe(20, n);
    checks++; if (left_out !== 16'h0100) begin errors++; $display("FAIL rm_pre got %h exp 0100", left_out); end
    rst = 0;
    #1;
    checks++; if ({write_audio_out, busy, active} !== 6'b0) begin errors++; $display("FAIL rm_ctrl got %b exp 0", {write_audio_out, busy, active}); end
    checks++; if ({left_out, right_out, rom_addr} !== 48'h0) begin errors++; $display("FAIL rm_data got %h exp 0", {left_out, right_out, rom_addr}); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_late_trigger;
    int n;
    clear_rom();
    for (int p = 0; p < SL; p++) begin
      rom[p] = {16'(256*(p+1)), 16'h0};
      rom[2*SL+p] = {16'(16*(p+1)), 16'(p+1)};
    end
    pulse(4'b0001);
    @(negedge clk);
    trigger = 4'b0100;
    @(negedge clk);
    trigger = '0;
    wait_strobe(20, n);
    checks++; if ({left_out, right_out} !== 32'h0100_0000) begin errors++; $display("FAIL lt_current got %h exp 01000000", {left_out, right_out}); end
    wait_strobe(20, n);
    checks++; if ({left_out, right_out} !== 32'h0210_0001) begin errors++; $display("FAIL lt_join got %h exp 02100001", {left_out, right_out}); end
    checks++; if (active !== 4'b0101) begin errors++; $display("FAIL lt_active got %b exp 0101", active); end
    trigger = 4'b0100;
    stop = 1;
    @(negedge clk);
    trigger = '0;
    stop = 0;
    @(negedge clk);
    checks++; if ({active, busy} !== 5'b0) begin errors++; $display("FAIL ts_state got %b exp 0", {active, busy}); end
    wait_strobe(30, n);
    checks++; if (n !== -1) begin errors++; $display("FAIL ts_ignored got strobe at %0d exp none", n); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_single_voice();
    test_saturation();
    test_retrigger_loop();
    test_backpressure();
    test_abort();
    test_reset_mid_output();
    test_late_trigger();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_voice_mixer.md
# sample_voice_mixer

Polyphonic sample-playback engine for the drum-machine audio path. It plays up to NUM_VOICES one-shot or looping samples from a shared stereo sample ROM and sums them with saturation into one stereo frame. Each frame is handed to the audio controller's output FIFO through the write_audio_out / audio_out_allowed handshake. It replaces the single-voice fixed-length player, and reads the ROM with a pipelined, time-multiplexed fetch.

## Interface
- NUM_VOICES, 4: number of voices. Voice v owns ROM region [v*SAMPLE_LEN, (v+1)*SAMPLE_LEN-1].
- SAMPLE_LEN, 4096: words per sample (power of two, ≥2).
- ADDR_W, 16: ROM address width. Elaboration error if NUM_VOICES*SAMPLE_LEN > 2^ADDR_W.
- DATA_W, 16: per-channel sample width, signed two's complement.
- ROM_LAT, 2: ROM read latency in clocks (≥1).
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- trigger  in  NUM_VOICES  one-cycle pulses, synchronous to clk; bit v (re)starts voice v.
- loop_en  in  NUM_VOICES  bit v high: voice v wraps instead of ending. Sampled on the last-sample fetch.
- stop  in  1  synchronous abort of all voices.
- audio_out_allowed  in  1  audio controller output FIFO has space.
- write_audio_out  out  1  one-cycle write strobe to the audio controller.
- left_out, right_out  out  DATA_W each  mixed frame; valid while write_audio_out is high.
- rom_addr  out  ADDR_W  ROM address.
- rom_q  in  2*DATA_W  ROM data: {left, right}, left in the upper half.
- active  out  NUM_VOICES  voice currently playing.
- busy  out  1  state ≠ IDLE.

## Operation
- Per-voice state:
  - pos[v]: clog2(SAMPLE_LEN) bits.
  - active[v].
  - pend[v]: pending trigger, set by trigger[v] in any state.
- States:
  - IDLE: entered when no voice is active and nothing is pending. Goes to WAIT_ALLOWED when any pend or trigger is seen.
  - WAIT_ALLOWED: advances to FETCH on an edge where audio_out_allowed=1. Apply-pending happens on that same edge: for each v with pend[v], pos[v]←0, active[v]←1, pend[v]←0.
  - FETCH: runs NUM_VOICES+ROM_LAT cycles, counted by k.
    - In cycle k<NUM_VOICES, rom_addr = k*SAMPLE_LEN + pos[k].
    - At the end of cycle k ≥ ROM_LAT, the accumulator adds rom_q for voice j=k-ROM_LAT. The add is gated to 0 if active[j]=0.
  - OUTPUT: 1 cycle. write_audio_out=1, and left_out/right_out hold the saturated sums. Position update happens on the exit edge (below).
  - GAP: 1 cycle, write_audio_out=0, so audio_out_allowed can settle. Next state is WAIT_ALLOWED if any active or pend bit is set, else IDLE.
- Position update on the OUTPUT exit edge, for each active voice:
  - pos < SAMPLE_LEN-1: pos+1.
  - pos = SAMPLE_LEN-1 and loop_en[v]: pos←0, voice stays active.
  - pos = SAMPLE_LEN-1 and not loop_en[v]: active[v]←0.
- Arithmetic:
  - Accumulators are signed, DATA_W+clog2(NUM_VOICES) bits, one per channel, cleared on FETCH entry.
  - Output is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Retrigger: a trigger on an active voice restarts it at pos 0 at the next frame start.
- Simultaneous events:
  - A trigger in the same frame as end-of-sample: the voice plays from pos 0 next frame.
  - A trigger in the same cycle as the WAIT_ALLOWED→FETCH edge: applied on that edge.
- stop: clears active and pend at the next edge, and any trigger in the same cycle is discarded. From any state, the block goes to IDLE with no write strobe. Outputs drop to 0 in IDLE.
- left_out/right_out are cleared to 0 on entering IDLE and otherwise update only in OUTPUT.

## Timing
- Reset values: write_audio_out=0, left_out=right_out=0, rom_addr=0, active=0, busy=0, all pos=0, pend=0, state=IDLE.
- Asynchronous reset mid-frame: immediate clear, no strobe.
- Frame period with audio_out_allowed held high: 1 (WAIT_ALLOWED) + NUM_VOICES + ROM_LAT + 1 (OUTPUT) + 1 (GAP). This is 9 clocks at default parameters.
- Trigger-to-first-strobe latency from IDLE: 1 + 1 + NUM_VOICES + ROM_LAT clocks, i.e. the strobe lands in cycle 8 after the trigger cycle.
- write_audio_out is never high for two consecutive cycles. Exactly one strobe is issued per frame.
- Backpressure: while audio_out_allowed=0 the block holds in WAIT_ALLOWED. pos does not advance and no strobe is issued. audio_out_allowed is ignored outside WAIT_ALLOWED.

## Test plan
- Single voice:
  - Setup: SAMPLE_LEN=8; voice 1 ROM holds L=pos*16'h0100, R=-L; trigger[1] pulse; audio_out_allowed=1.
  - Required: exactly 8 strobes, 9 clocks apart, carrying L=0x0000…0x0700 and the matching R values. active[1] drops after the 8th strobe, then IDLE and busy=0.
- Saturation:
  - All four voices 0x7000 → 0x7FFF.
  - All four 0x9000 → 0x8000.
  - All four 0x1000 → 0x4000.
  - Voices 0x7000 / 0x9000 / 0 / 0 → 0x0000.
- Retrigger and loop:
  - trigger[0] while voice 0 is at pos 5 → the next frame plays pos 0.
  - loop_en[0]=1 → pos 7 is followed by pos 0, with active[0] held high.
- Backpressure:
  - Hold audio_out_allowed=0 for 100 cycles after a strobe → no strobe, rom_addr does not step through voices, and pos is unchanged. On release, playback resumes at the next pos.
- Abort:
  - stop in FETCH cycle 2 → no strobe, active=0, state IDLE next cycle, and outputs 0.
  - rst low mid-OUTPUT → all outputs at reset values immediately.
- Late trigger:
  - trigger[2] during FETCH → voice 2 joins at pos 0 in the following frame, with no contribution to the current frame.
  - trigger[2] together with stop → ignored.
